// File: rtl/vault_pkg.sv
// Shared definitions for the vault puzzle chain: the sequencer state encoding,
// the phase indices and the default timing values.
package vault_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    RUN     = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } vault_state_e;

  localparam int PHASE_CODE_LOCK  = 0;
  localparam int PHASE_DIAL_LOCK  = 1;
  localparam int PHASE_PRINT_LOCK = 2;
  localparam int PHASE_VOICE_LOCK = 3;
  localparam int PHASE_TIME_LOCK  = 4;

  localparam int DEFAULT_NUM_PHASES     = 5;
  localparam int DEFAULT_RST_CYCLES     = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int DEFAULT_MAX_RETRIES    = 2;

endpackage

// File: rtl/vault_sequencer_if.sv
// Sequencer-to-phase bundle: start request, per-phase responses and controls,
// plus the status outputs of the sequencer.
interface vault_sequencer_if
  import vault_pkg::*;
#(
  parameter int NUM_PHASES = DEFAULT_NUM_PHASES
);
  logic                  start;
  logic [NUM_PHASES-1:0] phase_done;
  logic [NUM_PHASES-1:0] phase_fail;
  logic [NUM_PHASES-1:0] phase_rst;
  logic [NUM_PHASES-1:0] phase_en;
  logic [2:0]            cur_phase;
  logic [1:0]            retries_left;
  logic                  busy;
  logic                  vault_open;
  logic                  lockout;

  modport master (
    input  start, phase_done, phase_fail,
    output phase_rst, phase_en, cur_phase, retries_left, busy, vault_open, lockout
  );

  modport slave (
    output start, phase_done, phase_fail,
    input  phase_rst, phase_en, cur_phase, retries_left, busy, vault_open, lockout
  );
endinterface

// File: rtl/vault_timeout_timer.sv
// Attempt timer: counts RUN cycles of the active phase and flags the last
// cycle an attempt may use before it is treated as a failure.
module vault_timeout_timer
  import vault_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)    count_d = '0;
    else if (run) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expired = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/vault_sequencer.sv
// Vault chain master: arms and runs the phases in order, spends a shared retry
// budget on failed or timed-out attempts, and latches open or lockout.
module vault_sequencer
  import vault_pkg::*;
#(
  parameter int NUM_PHASES     = DEFAULT_NUM_PHASES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = DEFAULT_MAX_RETRIES,
  parameter int RST_CYCLES     = DEFAULT_RST_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  vault_sequencer_if.master bus
);
  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_ARM     = ARM;
  localparam logic [2:0] S_RUN     = RUN;
  localparam logic [2:0] S_OPEN    = OPEN;
  localparam logic [2:0] S_LOCKOUT = LOCKOUT;
  localparam int ARM_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic [2:0]            state_q, state_d;
  logic [ARM_W-1:0]      arm_cnt_q, arm_cnt_d;
  logic [2:0]            cur_phase_q, cur_phase_d;
  logic [1:0]            retries_left_q, retries_left_d;
  logic [NUM_PHASES-1:0] phase_rst_q, phase_rst_d;
  logic [NUM_PHASES-1:0] phase_en_q, phase_en_d;
  logic                  busy_q, busy_d;
  logic                  vault_open_q, vault_open_d;
  logic                  lockout_q, lockout_d;
  logic                  expired, cur_done, cur_fail, last_phase;

  vault_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != S_RUN),
    .run     (state_q == S_RUN),
    .expired (expired)
  );

  assign cur_done   = bus.phase_done[cur_phase_q];
  assign cur_fail   = bus.phase_fail[cur_phase_q];
  assign last_phase = (cur_phase_q == 3'(NUM_PHASES - 1));

  always_comb begin
    state_d        = state_q;
    arm_cnt_d      = arm_cnt_q;
    cur_phase_d    = cur_phase_q;
    retries_left_d = retries_left_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        cur_phase_d = 3'(PHASE_CODE_LOCK);
        arm_cnt_d   = '0;
        state_d     = S_ARM;
      end
      S_ARM: begin
        if (arm_cnt_q == ARM_W'(RST_CYCLES - 1)) state_d = S_RUN;
        else                                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
      end
      S_RUN: begin
        // Fail beats done; done on the final timer cycle still passes.
        if (cur_fail || (expired && !cur_done)) begin
          if (retries_left_q == 2'd0) begin
            state_d = S_LOCKOUT;
          end else begin
            retries_left_d = retries_left_q - 2'd1;
            arm_cnt_d      = '0;
            state_d        = S_ARM;
          end
        end else if (cur_done) begin
          if (last_phase) begin
            state_d = S_OPEN;
          end else begin
            cur_phase_d = cur_phase_q + 3'd1;
            arm_cnt_d   = '0;
            state_d     = S_ARM;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    phase_rst_d  = '1;
    phase_en_d   = '0;
    if (state_d == S_RUN) begin
      phase_en_d  = NUM_PHASES'(1) << cur_phase_d;
      phase_rst_d = ~phase_en_d;
    end
    busy_d       = (state_d == S_ARM) || (state_d == S_RUN);
    vault_open_d = (state_d == S_OPEN);
    lockout_d    = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      arm_cnt_q      <= '0;
      cur_phase_q    <= 3'(PHASE_CODE_LOCK);
      retries_left_q <= 2'(MAX_RETRIES);
      phase_rst_q    <= '1;
      phase_en_q     <= '0;
      busy_q         <= 1'b0;
      vault_open_q   <= 1'b0;
      lockout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      arm_cnt_q      <= arm_cnt_d;
      cur_phase_q    <= cur_phase_d;
      retries_left_q <= retries_left_d;
      phase_rst_q    <= phase_rst_d;
      phase_en_q     <= phase_en_d;
      busy_q         <= busy_d;
      vault_open_q   <= vault_open_d;
      lockout_q      <= lockout_d;
    end
  end

  assign bus.phase_rst    = phase_rst_q;
  assign bus.phase_en     = phase_en_q;
  assign bus.cur_phase    = cur_phase_q;
  assign bus.retries_left = retries_left_q;
  assign bus.busy         = busy_q;
  assign bus.vault_open   = vault_open_q;
  assign bus.lockout      = lockout_q;
endmodule

// File: tb/tb_vault_sequencer.sv
// Bench for vault_sequencer: each run is planned as a list of phase attempts,
// expanded into an expected per-cycle output trace and an open-loop stimulus trace.
module tb_vault_sequencer;
  import vault_pkg::*;

  localparam int NP = DEFAULT_NUM_PHASES;
  localparam int TO = DEFAULT_TIMEOUT_CYCLES;
  localparam int MR = DEFAULT_MAX_RETRIES;
  localparam int RC = DEFAULT_RST_CYCLES;

  // Attempt kinds: done, fail, done+fail, silent (timeout), done on last timer cycle.
  localparam int K_DONE = 0, K_FAIL = 1, K_BOTH = 2, K_NONE = 3, K_LATE = 4;
  // Trace modes for the expected outputs.
  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_OPEN = 3, M_LOCK = 4;

  typedef struct packed {
    logic [NP-1:0] prst;
    logic [NP-1:0] pen;
    logic [2:0]    cur;
    logic [1:0]    ret;
    logic          busy;
    logic          open;
    logic          lock;
  } exp_t;

  typedef struct packed {
    logic          rst;
    logic          start;
    logic [NP-1:0] done;
    logic [NP-1:0] fail;
  } stim_t;

  typedef struct packed {
    logic [2:0] kind;
    logic [6:0] j;
  } att_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vault_sequencer_if #(.NUM_PHASES(NP)) bus ();

  vault_sequencer #(
    .NUM_PHASES(NP), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR), .RST_CYCLES(RC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t  exp_q[$];
  stim_t stim_q[$];
  att_t  dir_q[$];
  exp_t  exp_now;
  exp_t  act_s;
  bit    chk_en = 1'b0;
  int    tests = 0;
  int    fails = 0;
  int    start_idx;

  function automatic exp_t mk_exp(int mode, int p, int r);
    exp_t e;
    e.prst = '1;
    e.pen  = '0;
    e.cur  = 3'(p);
    e.ret  = 2'(r);
    e.busy = (mode == M_ARM) || (mode == M_RUN);
    e.open = (mode == M_OPEN);
    e.lock = (mode == M_LOCK);
    if (mode == M_RUN) begin
      e.pen[p] = 1'b1;
      e.prst   = ~e.pen;
    end
    return e;
  endfunction

  function automatic stim_t rnd_stim(bit allow_start);
    stim_t s;
    s.rst   = 1'b0;
    s.start = allow_start ? 1'($urandom_range(0, 1)) : 1'b0;
    s.done  = NP'($urandom);
    s.fail  = NP'($urandom);
    return s;
  endfunction

  function automatic att_t rnd_att();
    att_t a;
    int   v;
    v = $urandom_range(0, 19);
    a.j = 7'($urandom_range(0, 7));
    if (v <= 10)      a.kind = 3'(K_DONE);
    else if (v <= 13) a.kind = 3'(K_FAIL);
    else if (v <= 15) a.kind = 3'(K_BOTH);
    else if (v <= 17) a.kind = 3'(K_NONE);
    else begin
      a.kind = 3'(K_LATE);
      a.j    = 7'(TO - 1);
    end
    return a;
  endfunction

  function automatic att_t att(int kind, int j);
    att_t a;
    a.kind = 3'(kind);
    a.j    = 7'(j);
    return a;
  endfunction

  task automatic push(input exp_t e, input stim_t s);
    exp_q.push_back(e);
    stim_q.push_back(s);
  endtask

  // Expand the attempt plan (directed list first, random afterwards) into traces.
  task automatic build(input int idle_n, input int abort_phase, input int tail_n);
    int    p, r, len, mode_end;
    att_t  a;
    stim_t s;
    exp_q.delete();
    stim_q.delete();
    p = 0;
    r = MR;
    for (int i = 0; i < idle_n; i++) push(mk_exp(M_IDLE, 0, MR), rnd_stim(1'b0));
    start_idx = idle_n;
    s = rnd_stim(1'b0);
    s.start = 1'b1;
    push(mk_exp(M_IDLE, 0, MR), s);
    mode_end = M_IDLE;
    while (mode_end == M_IDLE) begin
      if (dir_q.size() > 0) a = dir_q.pop_front();
      else                  a = rnd_att();
      for (int i = 0; i < RC; i++) push(mk_exp(M_ARM, p, r), rnd_stim(1'b1));
      len = (int'(a.kind) == K_NONE) ? TO : int'(a.j) + 1;
      for (int k = 0; k < len; k++) begin
        s = rnd_stim(1'b1);
        s.done[p] = 1'b0;
        s.fail[p] = 1'b0;
        if (k == len - 1) begin
          if (int'(a.kind) == K_DONE || int'(a.kind) == K_LATE) s.done[p] = 1'b1;
          if (int'(a.kind) == K_FAIL) s.fail[p] = 1'b1;
          if (int'(a.kind) == K_BOTH) begin
            s.done[p] = 1'b1;
            s.fail[p] = 1'b1;
          end
        end
        if (p == abort_phase && k == 0) begin
          s.rst = 1'b1;
          push(mk_exp(M_RUN, p, r), s);
          push(mk_exp(M_IDLE, 0, MR), '0);
          dir_q.delete();
          return;
        end
        push(mk_exp(M_RUN, p, r), s);
      end
      if (int'(a.kind) == K_FAIL || int'(a.kind) == K_BOTH || int'(a.kind) == K_NONE) begin
        if (r == 0) mode_end = M_LOCK;
        else        r = r - 1;
      end else if (p == NP - 1) begin
        mode_end = M_OPEN;
      end else begin
        p = p + 1;
      end
    end
    for (int i = 0; i < tail_n; i++) push(mk_exp(mode_end, p, r), rnd_stim(1'b1));
    dir_q.delete();
  endtask

  task automatic run_ep();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.phase_done = '0;
    bus.phase_fail = '0;
    @(posedge clk);
    for (int c = 0; c < exp_q.size(); c++) begin
      #1;
      exp_now        = exp_q[c];
      chk_en         = 1'b1;
      rst            = stim_q[c].rst;
      bus.start      = stim_q[c].start;
      bus.phase_done = stim_q[c].done;
      bus.phase_fail = stim_q[c].fail;
      @(posedge clk);
    end
    #1 chk_en = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic int first_open();
    for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].open) return i;
    return -1;
  endfunction

  function automatic int first_lock();
    for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].lock) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      act_s.prst = bus.phase_rst;
      act_s.pen  = bus.phase_en;
      act_s.cur  = bus.cur_phase;
      act_s.ret  = bus.retries_left;
      act_s.busy = bus.busy;
      act_s.open = bus.vault_open;
      act_s.lock = bus.lockout;
      tests++;
      if (act_s !== exp_now) begin
        fails++;
        $display("FAIL cycle_check t=%0t: got rst=%b en=%b cur=%0d ret=%0d busy=%b open=%b lock=%b, expected rst=%b en=%b cur=%0d ret=%0d busy=%b open=%b lock=%b",
                 $time, act_s.prst, act_s.pen, act_s.cur, act_s.ret, act_s.busy, act_s.open, act_s.lock,
                 exp_now.prst, exp_now.pen, exp_now.cur, exp_now.ret, exp_now.busy, exp_now.open, exp_now.lock);
      end
    end
  end

  initial begin
    int cnt;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.phase_done = '0;
    bus.phase_fail = '0;
    repeat (2) @(posedge clk);

    // Happy path: every phase answers on its first RUN cycle.
    for (int i = 0; i < NP; i++) dir_q.push_back(att(K_DONE, 0));
    build(3, -1, 6);
    check_int("happy_open_latency", first_open() - (start_idx + 1), 15);
    check_int("happy_retries", int'(exp_q[exp_q.size()-1].ret), 2);
    run_ep();
    check_int("happy_dut_open", int'(bus.vault_open), 1);
    check_int("happy_dut_lock", int'(bus.lockout), 0);

    // Phase 2 fails once, then passes.
    dir_q.push_back(att(K_DONE, 1));
    dir_q.push_back(att(K_DONE, 1));
    dir_q.push_back(att(K_FAIL, 2));
    dir_q.push_back(att(K_DONE, 1));
    dir_q.push_back(att(K_DONE, 0));
    dir_q.push_back(att(K_DONE, 0));
    build(1, -1, 4);
    cnt = 0;
    foreach (exp_q[i]) if (exp_q[i].busy && exp_q[i].cur == 3'd2 && exp_q[i].pen == '0) cnt++;
    check_int("retry_phase2_arm_cycles", cnt, 4);
    check_int("retry_retries_left", int'(exp_q[exp_q.size()-1].ret), 1);
    run_ep();
    check_int("retry_dut_retries", int'(bus.retries_left), 1);

    // Phase 3 never answers: three timeouts exhaust the budget.
    for (int i = 0; i < 3; i++) dir_q.push_back(att(K_DONE, 0));
    for (int i = 0; i < 3; i++) dir_q.push_back(att(K_NONE, 0));
    build(2, -1, 5);
    check_int("timeout_lock_latency", first_lock() - (start_idx + 1), 3 * (RC + 1) + 3 * (RC + TO));
    check_int("timeout_lock_prst", int'(exp_q[exp_q.size()-1].prst), 31);
    run_ep();
    check_int("timeout_dut_lock", int'(bus.lockout), 1);
    check_int("timeout_dut_prst", int'(bus.phase_rst), 31);

    // Simultaneous done+fail on phase 0 counts as a fail.
    dir_q.push_back(att(K_BOTH, 0));
    for (int i = 0; i < NP; i++) dir_q.push_back(att(K_DONE, 2));
    build(0, -1, 4);
    check_int("both_retries_left", int'(exp_q[exp_q.size()-1].ret), 1);
    run_ep();

    // Reset on the first RUN cycle of phase 1.
    dir_q.push_back(att(K_DONE, 0));
    build(1, 1, 0);
    check_int("abort_prst", int'(exp_q[exp_q.size()-1].prst), 31);
    run_ep();
    check_int("abort_dut_retries", int'(bus.retries_left), 2);
    check_int("abort_dut_busy", int'(bus.busy), 0);

    // Done on the timeout cycle itself passes.
    dir_q.push_back(att(K_LATE, TO - 1));
    for (int i = 1; i < NP; i++) dir_q.push_back(att(K_DONE, 0));
    build(0, -1, 3);
    cnt = 0;
    foreach (exp_q[i]) if (exp_q[i].pen[0]) cnt++;
    check_int("late_done_run_cycles", cnt, TO);
    run_ep();
    check_int("late_done_dut_retries", int'(bus.retries_left), 2);

    // Randomized runs, some with a mid-run reset.
    for (int e = 0; e < 25; e++) begin
      build($urandom_range(0, 4), ($urandom_range(0, 3) == 0) ? $urandom_range(0, NP - 1) : -1, 6);
      run_ep();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
